// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg -- shared types, constants and board helpers for the
// tic-tac-toe referee (tictactoe) and its AI move selector (tictactoe_ai).
//
// Contents:
//   cell_t      cell encoding: EMPTY=00, X=01, O=10
//   NONE/XWIN/OWIN/DRAW  game status codes carried on the win output
//   board_t     3x3 packed board, indexed board[row][col]
//   WIN_LINES   the 8 winning lines as flat cell indices (row*3+col)
//   cell_index / cell_at / set_cell   flat-index helpers
//   eval_board  line/draw evaluation shared by the top level and the AI
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  // The status code for a win equals the winner's cell code, which lets
  // eval_board report a winner by returning the cell value directly.
  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] XWIN = 2'b01;
  localparam logic [1:0] OWIN = 2'b10;
  localparam logic [1:0] DRAW = 2'b11;

  // Row-major packing: cell (r,c) sits at flat bits [2*(3r+c) +: 2].
  typedef logic [2:0][2:0][1:0] board_t;

  localparam int NUM_LINES = 8;

  // Each entry is {a, b, c}, three 4-bit flat cell indices. Packed
  // concatenation lists the highest entry first, so line 0 is the last row.
  localparam logic [NUM_LINES-1:0][11:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6},   // 7: anti-diagonal
    {4'd0, 4'd4, 4'd8},   // 6: diagonal
    {4'd2, 4'd5, 4'd8},   // 5: column 2
    {4'd1, 4'd4, 4'd7},   // 4: column 1
    {4'd0, 4'd3, 4'd6},   // 3: column 0
    {4'd6, 4'd7, 4'd8},   // 2: row 2
    {4'd3, 4'd4, 4'd5},   // 1: row 1
    {4'd0, 4'd1, 4'd2}    // 0: row 0
  };

  function automatic logic [3:0] cell_index(input logic [1:0] row,
                                            input logic [1:0] col);
    return 4'(row) * 4'd3 + 4'(col);
  endfunction

  function automatic logic [1:0] cell_at(input board_t b, input logic [3:0] idx);
    logic [17:0] flat;
    flat = b;
    return flat[{idx, 1'b0} +: 2];
  endfunction

  function automatic board_t set_cell(input board_t b, input logic [3:0] idx,
                                      input logic [1:0] v);
    logic [17:0] flat;
    flat = b;
    flat[{idx, 1'b0} +: 2] = v;
    return flat;
  endfunction

  // Returns XWIN/OWIN if any line is complete, else DRAW if no cell is
  // empty, else NONE. A completed line takes precedence over a full board.
  function automatic logic [1:0] eval_board(input board_t b);
    logic [1:0] status;
    logic [1:0] ca, cb, cc;
    logic       full;
    status = NONE;
    full   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cell_at(b, 4'(i)) == EMPTY) full = 1'b0;
    end
    for (int l = 0; l < NUM_LINES; l++) begin
      ca = cell_at(b, WIN_LINES[l][11:8]);
      cb = cell_at(b, WIN_LINES[l][7:4]);
      cc = cell_at(b, WIN_LINES[l][3:0]);
      if (status == NONE && ca != EMPTY && ca == cb && ca == cc) status = ca;
    end
    if (status == NONE && full) status = DRAW;
    return status;
  endfunction

endpackage

// File: rtl/tictactoe_ai.sv
// tictactoe_ai -- combinational AI move selector.
//
// Ports:
//   board   in  current board (after the human move being answered)
//   ai_sym  in  symbol the AI plays (X or O)
//   row     out chosen row
//   col     out chosen column
//   valid   out 1 when an empty cell exists (a move was chosen)
//
// Priority: immediate AI win, then block a human win (both scanning flat
// index 0..8 so the lowest row*3+col wins ties), then centre, corners,
// edges in a fixed order.
module tictactoe_ai
  import tictactoe_pkg::*;
(
  input  board_t     board,
  input  logic [1:0] ai_sym,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       valid
);

  // Fallback order, entry 0 first: centre, corners, edges.
  localparam logic [8:0][3:0] FALLBACK = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
  };

  logic [1:0] human_sym;
  logic       found_win, found_block, found_free;
  logic [3:0] pick_win, pick_block, pick_free, pick;

  always_comb begin
    human_sym   = ai_sym ^ 2'b11;
    found_win   = 1'b0;
    found_block = 1'b0;
    found_free  = 1'b0;
    pick_win    = 4'd0;
    pick_block  = 4'd0;
    pick_free   = 4'd0;

    for (int k = 0; k < 9; k++) begin
      if (cell_at(board, 4'(k)) == EMPTY) begin
        if (!found_win &&
            eval_board(set_cell(board, 4'(k), ai_sym)) == ai_sym) begin
          found_win = 1'b1;
          pick_win  = 4'(k);
        end
        if (!found_block &&
            eval_board(set_cell(board, 4'(k), human_sym)) == human_sym) begin
          found_block = 1'b1;
          pick_block  = 4'(k);
        end
      end
    end

    for (int f = 0; f < 9; f++) begin
      if (!found_free && cell_at(board, FALLBACK[f]) == EMPTY) begin
        found_free = 1'b1;
        pick_free  = FALLBACK[f];
      end
    end

    valid = found_win | found_block | found_free;
    if (found_win)        pick = pick_win;
    else if (found_block) pick = pick_block;
    else                  pick = pick_free;
    row = 2'(pick / 4'd3);
    col = 2'(pick % 4'd3);
  end

endmodule

// File: rtl/tictactoe.sv
// tictactoe -- tic-tac-toe referee with optional AI opponent.
//
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous, active-low
//   xoroin   in  move request: 00 none, 01 X, 10 O, 11 illegal
//   rowin    in  target row (0..2, 3 illegal)
//   colin    in  target column (0..2, 3 illegal)
//   ai_en    in  answer each accepted human move with an AI move
//   err      out registered one-cycle pulse on a rejected request
//   xoroout  out registered symbol of the last committed move
//   rowout   out registered row of the last committed move
//   colout   out registered column of the last committed move
//   win      out registered status: 00 play, 01 X won, 10 O won, 11 draw
//
// Configuration: define TTT_AI_EN to build in the AI selector; without it
// ai_en is ignored and the block is a two-human referee.
//
// Request semantics: a nonzero xoroin is a one-cycle request sampled on the
// rising edge. There is no back-pressure; the outcome is visible on the
// registered outputs one cycle later (err=1 for reject, move shown for
// accept). xoroin=00 is idle: err returns to 0 and other outputs hold.
module tictactoe
  import tictactoe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] xoroin,
  input  logic [1:0] rowin,
  input  logic [1:0] colin,
  input  logic       ai_en,
  output logic       err,
  output logic [1:0] xoroout,
  output logic [1:0] rowout,
  output logic [1:0] colout,
  output logic [1:0] win
);

  board_t     board_q, board_d;
  logic [1:0] turn_q, turn_d;
  logic       err_d;
  logic [1:0] xoroout_d, rowout_d, colout_d, win_d;

  logic       req, in_range, legal;
  logic [3:0] target;
  board_t     board_h;
  logic [1:0] status_h;

  assign req      = (xoroin != 2'b00);
  assign in_range = (rowin <= 2'd2) && (colin <= 2'd2);
  // Out-of-range coordinates are rejected; steer the index to cell 0 so
  // the board lookup stays in bounds.
  assign target   = in_range ? cell_index(rowin, colin) : 4'd0;
  // turn_q is only ever X or O, so a match also excludes xoroin = 11.
  assign legal    = req && (xoroin == turn_q) && in_range &&
                    (cell_at(board_q, target) == EMPTY) && (win == NONE);
  assign board_h  = set_cell(board_q, target, xoroin);
  assign status_h = eval_board(board_h);

`ifdef TTT_AI_EN
  logic [1:0] ai_sym, ai_row, ai_col, status_ai;
  logic       ai_valid;
  board_t     board_ai;

  // Only consulted when the request is legal, i.e. xoroin == turn_q.
  assign ai_sym = turn_q ^ 2'b11;

  tictactoe_ai u_ai (
    .board  (board_h),
    .ai_sym (ai_sym),
    .row    (ai_row),
    .col    (ai_col),
    .valid  (ai_valid)
  );

  assign board_ai  = set_cell(board_h, cell_index(ai_row, ai_col), ai_sym);
  assign status_ai = eval_board(board_ai);
`else
  logic unused_ai_en;
  assign unused_ai_en = ai_en;
`endif

  always_comb begin
    board_d   = board_q;
    turn_d    = turn_q;
    err_d     = 1'b0;
    xoroout_d = xoroout;
    rowout_d  = rowout;
    colout_d  = colout;
    win_d     = win;

    if (req && !legal) begin
      err_d = 1'b1;
    end else if (legal) begin
      board_d   = board_h;
      turn_d    = turn_q ^ 2'b11;
      xoroout_d = xoroin;
      rowout_d  = rowin;
      colout_d  = colin;
      win_d     = status_h;
`ifdef TTT_AI_EN
      // The AI replies in the same edge, so the turn comes back to the human.
      if (ai_en && (status_h == NONE) && ai_valid) begin
        board_d   = board_ai;
        turn_d    = turn_q;
        xoroout_d = ai_sym;
        rowout_d  = ai_row;
        colout_d  = ai_col;
        win_d     = status_ai;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      board_q <= '0;
      turn_q  <= X;
      err     <= 1'b0;
      xoroout <= 2'b00;
      rowout  <= 2'b00;
      colout  <= 2'b00;
      win     <= NONE;
    end else begin
      board_q <= board_d;
      turn_q  <= turn_d;
      err     <= err_d;
      xoroout <= xoroout_d;
      rowout  <= rowout_d;
      colout  <= colout_d;
      win     <= win_d;
    end
  end

endmodule

// File: tb/tb_tictactoe.sv
// tb_tictactoe -- bench for tictactoe. Drives requests, keeps an
// independent board model, and compares {err, xoroout, rowout, colout, win}
// one edge later. AI-specific expectations apply when TTT_AI_EN is defined.
module tb_tictactoe;

  localparam int W = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] xoroin, rowin, colin;
  logic       ai_en;
  logic       err;
  logic [1:0] xoroout, rowout, colout, win;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state.
  logic [8:0][1:0] m_board;
  logic [1:0]      m_turn, m_xo, m_row, m_col, m_win;
  logic            m_err;

  tictactoe dut (
    .clk     (clk),
    .reset   (reset),
    .xoroin  (xoroin),
    .rowin   (rowin),
    .colin   (colin),
    .ai_en   (ai_en),
    .err     (err),
    .xoroout (xoroout),
    .rowout  (rowout),
    .colout  (colout),
    .win     (win)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) e = 'x;
    else                   e = exp_q.pop_front();
    check(tag, {err, xoroout, rowout, colout, win}, e);
  endtask

  // ---------------- model ----------------
  function automatic logic [1:0] m_status(input logic [8:0][1:0] b);
    logic [1:0] s;
    s = 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (b[3*i] != 2'b00 && b[3*i] == b[3*i+1] && b[3*i] == b[3*i+2]) s = b[3*i];
      if (b[i] != 2'b00 && b[i] == b[i+3] && b[i] == b[i+6]) s = b[i];
    end
    if (b[4] != 2'b00 && ((b[0] == b[4] && b[8] == b[4]) ||
                          (b[2] == b[4] && b[6] == b[4]))) s = b[4];
    if (s == 2'b00) begin
      s = 2'b11;
      for (int k = 0; k < 9; k++) if (b[k] == 2'b00) s = 2'b00;
    end
    return s;
  endfunction

`ifdef TTT_AI_EN
  function automatic int m_ai(input logic [8:0][1:0] b, input logic [1:0] me);
    logic [8:0][1:0] t;
    int order[9];
    logic [1:0] opp;
    order = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
    opp = me ^ 2'b11;
    for (int k = 0; k < 9; k++)
      if (b[k] == 2'b00) begin t = b; t[k] = me; if (m_status(t) == me) return k; end
    for (int k = 0; k < 9; k++)
      if (b[k] == 2'b00) begin t = b; t[k] = opp; if (m_status(t) == opp) return k; end
    for (int i = 0; i < 9; i++) if (b[order[i]] == 2'b00) return order[i];
    return 0;
  endfunction
`endif

  task automatic model_reset();
    m_board = '0;
    m_turn  = 2'b01;
    m_err   = 1'b0;
    m_xo    = 2'b00;
    m_row   = 2'b00;
    m_col   = 2'b00;
    m_win   = 2'b00;
  endtask

  task automatic model_req(input logic [1:0] sym, input logic [1:0] r,
                           input logic [1:0] c);
    int   k;
    logic ok;
    m_err = 1'b0;
    if (sym != 2'b00) begin
      ok = (sym == m_turn) && (r <= 2'd2) && (c <= 2'd2) && (m_win == 2'b00);
      k  = 0;
      if (ok) begin
        k  = int'(r) * 3 + int'(c);
        ok = (m_board[k] == 2'b00);
      end
      if (!ok) begin
        m_err = 1'b1;
      end else begin
        m_board[k] = sym;
        m_xo  = sym;
        m_row = r;
        m_col = c;
        m_win = m_status(m_board);
        m_turn = (sym == 2'b01) ? 2'b10 : 2'b01;
`ifdef TTT_AI_EN
        if (ai_en && m_win == 2'b00) begin
          k = m_ai(m_board, m_turn);
          m_board[k] = m_turn;
          m_xo   = m_turn;
          m_row  = 2'(k / 3);
          m_col  = 2'(k % 3);
          m_win  = m_status(m_board);
          m_turn = sym;
        end
`endif
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_req(input string tag, input logic [1:0] sym,
                        input logic [1:0] r, input logic [1:0] c, input logic ai);
    @(negedge clk);
    xoroin = sym;
    rowin  = r;
    colin  = c;
    ai_en  = ai;
    model_req(sym, r, c);
    exp_q.push_back({m_err, m_xo, m_row, m_col, m_win});
    @(posedge clk);
    #1;
    xoroin = 2'b00;
    sb_compare(tag);
  endtask

  // Reset with a simultaneous legal-looking request, which must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    xoroin = 2'b01;
    rowin  = 2'd2;
    colin  = 2'd2;
    model_reset();
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    xoroin = 2'b00;
    sb_compare("reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] seq_r[9], seq_c[9];
    logic [1:0] sym, r, c;

    reset = 1'b0; xoroin = 2'b00; rowin = 2'b00; colin = 2'b00; ai_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    do_reset();
    check("reset_win", W'(win), W'(0));

    // First legal move.
    do_req("x00", 2'b01, 2'd0, 2'd0, 1'b0);
    check("x00_out", W'({err, xoroout, rowout, colout, win}), W'(9'b0_01_00_00_00));

    // Rejections leave the last move on the outputs.
    do_req("x11_wrong_turn", 2'b01, 2'd1, 2'd1, 1'b0);
    check("wrong_turn_err", W'(err), W'(1));
    do_req("o00_occupied", 2'b10, 2'd0, 2'd0, 1'b0);
    check("occupied_err_hold", W'({err, xoroout, rowout, colout}), W'(7'b1_01_00_00));
    do_req("o_row3", 2'b10, 2'd3, 2'd0, 1'b0);
    check("row3_err", W'(err), W'(1));
    do_req("o_col3", 2'b10, 2'd0, 2'd3, 1'b0);
    do_req("sym11", 2'b11, 2'd2, 2'd2, 1'b0);
    do_req("idle", 2'b00, 2'd0, 2'd0, 1'b0);
    check("idle_err_low", W'(err), W'(0));

    // X wins on the top row, then the game is closed.
    do_reset();
    seq_r = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    seq_c = '{0, 0, 1, 1, 2, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++)
      do_req("xwin_seq", (i % 2 == 0) ? 2'b01 : 2'b10, seq_r[i], seq_c[i], 1'b0);
    check("xwin_status", W'(win), W'(2'b01));
    do_req("after_win", 2'b10, 2'd2, 2'd2, 1'b0);
    check("after_win_err", W'({err, win}), W'(3'b1_01));

    // Draw on the final (ninth) move.
    do_reset();
    seq_r = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    seq_c = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    for (int i = 0; i < 9; i++)
      do_req("draw_seq", (i % 2 == 0) ? 2'b01 : 2'b10, seq_r[i], seq_c[i], 1'b0);
    check("draw_status", W'(win), W'(2'b11));
    do_req("after_draw", 2'b10, 2'd0, 2'd0, 1'b0);

    // Mid-game reset discards the game; board is free again.
    do_reset();
    do_req("mid_x00", 2'b01, 2'd0, 2'd0, 1'b0);
    do_req("mid_o11", 2'b10, 2'd1, 2'd1, 1'b0);
    do_reset();
    check("mid_reset_zero", W'({err, xoroout, rowout, colout, win}), W'(0));
    do_req("post_reset_x00", 2'b01, 2'd0, 2'd0, 1'b0);
    check("post_reset_accept", W'({err, xoroout}), W'(3'b0_01));

    // AI opponent (or its absence).
    do_reset();
    do_req("ai_x00", 2'b01, 2'd0, 2'd0, 1'b1);
`ifdef TTT_AI_EN
    check("ai_centre", W'({xoroout, rowout, colout}), W'(6'b10_01_01));
    do_req("ai_x01", 2'b01, 2'd0, 2'd1, 1'b1);
    check("ai_block", W'({xoroout, rowout, colout}), W'(6'b10_00_10));
`else
    check("no_ai_x00", W'({xoroout, rowout, colout}), W'(6'b01_00_00));
    do_req("no_ai_turn_o", 2'b01, 2'd0, 2'd1, 1'b1);
    check("no_ai_reject_x", W'(err), W'(1));
`endif

    // Randomised play, mostly on-turn and in-range, with periodic resets.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ((m_win != 2'b00 && $urandom_range(0, 2) == 0) || $urandom_range(0, 39) == 0)
        do_reset();
      sym = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : m_turn;
      r   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      c   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req("random", sym, r, c, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
